// File: rtl/prog_clk_div_pkg.sv
// Shared constants, channel state type and the high-phase helper for the
// programmable clock-enable divider.
package clkdiv_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned CW_DEF  = 8;
  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    ChStopped,
    ChRunning
  } chan_st_e;

  // High-phase length ceil(d/2); the sum is done in 17 bits so d=2^16-1 cannot wrap.
  function automatic logic [15:0] half_hi(input logic [15:0] d);
    logic [16:0] sum;
    sum = {1'b0, d} + 17'd1;
    return sum[16:1];
  endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Configuration and output bundle of prog_clk_div; the master writes divisors,
// the slave (the divider) returns ready and the per-channel waveforms.
interface prog_clk_div_if #(
  parameter int unsigned NCH = clkdiv_pkg::NCH_DEF,
  parameter int unsigned CW  = clkdiv_pkg::CW_DEF
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [NCH-1:0] div_out;
  logic [NCH-1:0] tick;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready,
    input  div_out,
    input  tick
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready,
    output div_out,
    output tick
  );

endinterface

// File: rtl/prog_clk_div_chan.sv
// One divider channel: active/shadow divisor, pending flag, period counter and
// registered waveform/tick. A new divisor is adopted only at a period boundary.
module clkdiv_chan #(
  parameter int unsigned CW = clkdiv_pkg::CW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_wr,
  input  logic [CW-1:0] i_div,
  input  logic          i_sync,
  output logic          o_pend,
  output logic          o_div_out,
  output logic          o_tick
);

  import clkdiv_pkg::*;

  logic [CW-1:0] r_div;
  logic [CW-1:0] r_shadow;
  logic          r_pend;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          r_tick;

  chan_st_e      w_state;
  logic          w_end;
  logic          w_apply;
  logic          w_start;
  logic [CW-1:0] w_cnt_n;
  logic [CW-1:0] w_half;

  assign w_state = (r_div < CW'(DIV_MIN)) ? ChStopped : ChRunning;
  assign w_end   = (w_state == ChRunning) && (r_cnt == r_div - CW'(1));
  // A stopped channel has no period to finish, so a pending write applies at once.
  assign w_apply = r_pend && ((w_state == ChStopped) || w_end);
  assign w_start = (r_shadow >= CW'(DIV_MIN));
  assign w_cnt_n = w_end ? '0 : r_cnt + CW'(1);
  assign w_half  = CW'(half_hi(16'(r_div)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div    <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div  <= r_shadow;
        r_pend <= 1'b0;
      end else if (i_wr) begin
        r_shadow <= i_div;
        r_pend   <= 1'b1;
      end

      if (w_apply) begin
        r_cnt  <= '0;
        r_out  <= w_start;
        r_tick <= w_start;
      end else if (w_state == ChStopped) begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (i_sync) begin
        r_cnt  <= '0;
        r_out  <= 1'b1;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= w_cnt_n;
        r_out  <= (w_cnt_n < w_half);
        r_tick <= (w_cnt_n == '0);
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_div_out = r_out;
  assign o_tick    = r_tick;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock-enable divider: config decode, ready mux and
// output gathering. Defining CLKDIV_SYNC_EN adds the sync restart input.
module prog_clk_div #(
  parameter int unsigned NCH = clkdiv_pkg::NCH_DEF,
  parameter int unsigned CW  = clkdiv_pkg::CW_DEF
) (
  input  logic           clk,
  input  logic           resetn,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  prog_clk_div_if.slave  bus
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PAD = 1 << CHW;

  logic [NCH-1:0] w_pend;
  logic [PAD-1:0] w_pend_pad;
  logic           w_ready;
  logic [NCH-1:0] w_wr;
  logic [NCH-1:0] w_div_out;
  logic [NCH-1:0] w_tick;
  logic           w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Unused channel codes read as never-pending, so such writes are accepted and dropped.
  always_comb begin
    w_pend_pad             = '0;
    w_pend_pad[NCH-1:0]    = w_pend;
  end

  assign w_ready       = !w_pend_pad[bus.cfg_ch];
  assign bus.cfg_ready = w_ready;

  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wr[i] = bus.cfg_valid && w_ready && (int'(bus.cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkdiv_chan #(
      .CW (CW)
    ) u_chan (
      .clk       (clk),
      .resetn    (resetn),
      .i_wr      (w_wr[g]),
      .i_div     (bus.cfg_div),
      .i_sync    (w_sync),
      .o_pend    (w_pend[g]),
      .o_div_out (w_div_out[g]),
      .o_tick    (w_tick[g])
    );
  end

  assign bus.div_out = w_div_out;
  assign bus.tick    = w_tick;

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: stimulus pushes hand-derived per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_prog_clk_div;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic clk;
  logic resetn;
`ifdef CLKDIV_SYNC_EN
  logic sync;
`endif

  prog_clk_div_if #(.NCH(NCH), .CW(CW)) bus ();

  prog_clk_div #(
    .NCH (NCH),
    .CW  (CW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
`ifdef CLKDIV_SYNC_EN
    .sync   (sync),
`endif
    .bus    (bus)
  );

  // Divisor d takes effect for channel ch at edge number 'at' (d<2 means stopped).
  typedef struct {
    int ch;
    int at;
    int d;
  } sched_t;

  typedef struct {
    logic [3:0] d;
    logic [3:0] t;
    logic [3:0] r;
    int         e;
  } exp_t;

  sched_t sched_q[$];
  exp_t   exp_q[$];
  int     total;
  int     bad;
  int     ecnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit pat(input int d, input int ph);
    string s;
    case (d)
      2:       s = "10";
      3:       s = "110";
      4:       s = "1100";
      5:       s = "11100";
      6:       s = "111000";
      default: s = "0";
    endcase
    return s[ph] == "1";
  endfunction

  task automatic expect_at(input int e, output logic [3:0] d, output logic [3:0] t);
    d = '0;
    t = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      int best = -1;
      int bd   = 0;
      foreach (sched_q[k]) begin
        if (sched_q[k].ch == ch && sched_q[k].at <= e && sched_q[k].at >= best) begin
          best = sched_q[k].at;
          bd   = sched_q[k].d;
        end
      end
      if (best >= 0 && bd >= 2) begin
        int ph = (e - best) % bd;
        d[ch] = pat(bd, ph);
        t[ch] = (ph == 0);
      end
    end
  endtask

  task automatic add(input int ch, input int at, input int d);
    sched_t s;
    s.ch = ch;
    s.at = at;
    s.d  = d;
    sched_q.push_back(s);
  endtask

  task automatic push_exp(input bit rdy);
    exp_t x;
    expect_at(ecnt, x.d, x.t);
    x.r = {3'b000, rdy};
    x.e = ecnt;
    exp_q.push_back(x);
  endtask

  task automatic step(input bit v, input int ch, input int div, input bit rdy);
    @(posedge clk);
    ecnt++;
    #1;
    bus.cfg_valid = v;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_div   = 8'(div);
    push_exp(rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, int'(bus.cfg_ch), 0, rdy);
  endtask

  task automatic check(input string name, input int e, input logic [3:0] act,
                       input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, e, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("div_out", x.e, bus.div_out, x.d);
      check("tick", x.e, bus.tick, x.t);
      check("cfg_ready", x.e, {3'b000, bus.cfg_ready}, x.r);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    total         = 0;
    bad           = 0;
    ecnt          = 0;
    resetn        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
    sync          = 1'b0;
`endif

    // Held in reset: everything stopped, nothing pending.
    idle(3, 1'b1);
    resetn = 1'b1;
    ecnt   = 0;

    // Stopped channels start one edge after the accepting edge.
    step(1'b1, 0, 2, 1'b1); add(0, 3, 2);
    step(1'b1, 1, 4, 1'b1); add(1, 4, 4);
    step(1'b1, 2, 6, 1'b1); add(2, 5, 6);
    step(1'b1, 3, 5, 1'b1); add(3, 6, 5);
    idle(1, 1'b0);
    idle(16, 1'b1);

    // ch3 5 -> 3 mid-period: boundaries of ch3 are 6,11,16,21,26.
    step(1'b1, 3, 3, 1'b1); add(3, 26, 3);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // ch0 back-to-back: accept at 31 is on a boundary so it waits until 33.
    step(1'b1, 0, 4, 1'b1); add(0, 33, 4);
    step(1'b1, 0, 6, 1'b0);
    step(1'b1, 0, 6, 1'b0);
    step(1'b1, 0, 6, 1'b1); add(0, 37, 6);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // ch1 stop while running at 4: its period ends at 44.
    step(1'b1, 1, 0, 1'b1); add(1, 44, 0);
    idle(2, 1'b0);
    idle(16, 1'b1);

    // Asynchronous reset between edges, while ch2/ch3 are high.
    @(posedge clk);
    ecnt++;
    #1;
    bus.cfg_valid = 1'b0;
    resetn        = 1'b0;
    sched_q.delete();
    push_exp(1'b1);
    idle(2, 1'b1);
    resetn = 1'b1;
    ecnt   = 0;
    idle(10, 1'b1);

`ifdef CLKDIV_SYNC_EN
    step(1'b1, 0, 4, 1'b1); add(0, 13, 4);
    step(1'b1, 1, 6, 1'b1); add(1, 14, 6);
    idle(1, 1'b0);
    idle(8, 1'b1);
    sync = 1'b1;
    add(0, 22, 4);
    add(1, 22, 6);
    idle(1, 1'b1);
    sync = 1'b0;
    idle(28, 1'b1);
`endif

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
